// File: rtl/fpu_read_fill_ctrl.sv
// fpu_read_fill_ctrl: fills a BUFFER_DEPTH x COL_WIDTH request buffer from DRAM rows, with up to MAX_OUTSTANDING reads in flight.
// Define FPU_FILL_ERR_CHECK_EN to flag stray response beats on a sticky err output.
module fpu_read_fill_ctrl #(
  parameter int BUFFER_DEPTH = 512,
  parameter int COL_WIDTH = 10,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BADDR_BITS = $clog2(BUFFER_DEPTH),
  localparam int CADDR_BITS = $clog2(COL_WIDTH),
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [31:0]                      base_addr,
  input  logic [31:0]                      stride,
  input  logic [BADDR_BITS:0]              width,
  input  logic [CADDR_BITS:0]              height,
  output logic                             req_valid,
  output logic [31:0]                      req_addr,
  input  logic                             req_ready,
  input  logic                             rsp_valid,
  input  logic [63:0]                      rsp_data,
  output logic                             buf_wr_en,
  output logic [BADDR_BITS+CADDR_BITS-1:0] buf_wr_addr,
  output logic [63:0]                      buf_wr_data,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] row_base_q, req_addr_q, stride_q;
  logic [BADDR_BITS:0] bpr_q, req_beat_q, rsp_beat_q;
  logic [CADDR_BITS:0] height_q, req_row_q, rsp_row_q;
  logic [OW-1:0] out_q;
  logic wr_en_q, wr_last_q;
  logic [BADDR_BITS+CADDR_BITS-1:0] wr_addr_q;
  logic [63:0] wr_data_q;
  logic [BADDR_BITS+1:0] w_ext;
  logic go, accept, rsp_ok, req_beat_last, req_last, rsp_beat_last, rsp_last;
  assign w_ext = {1'b0, width} + (BADDR_BITS+2)'(7);
  assign go = state_q == IDLE && start;
  assign req_valid = state_q == REQ && out_q < OW'(MAX_OUTSTANDING);
  assign accept = req_valid && req_ready;
  // beats only count while a fill owns them; anything else is stray
  assign rsp_ok = rsp_valid && state_q != IDLE && out_q != '0;
  assign req_beat_last = req_beat_q == bpr_q - (BADDR_BITS+1)'(1);
  assign req_last = req_beat_last && req_row_q == height_q - (CADDR_BITS+1)'(1);
  assign rsp_beat_last = rsp_beat_q == bpr_q - (BADDR_BITS+1)'(1);
  assign rsp_last = rsp_beat_last && rsp_row_q == height_q - (CADDR_BITS+1)'(1);
  assign req_addr = req_addr_q;
  assign buf_wr_en = wr_en_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (width == '0 || height == '0) ? DONE : REQ;
      REQ:     if (accept && req_last) state_d = DRAIN;
      DRAIN:   if (wr_en_q && wr_last_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base_q <= '0;
      req_addr_q <= '0;
      stride_q <= '0;
      bpr_q <= '0;
      height_q <= '0;
      req_beat_q <= '0;
      req_row_q <= '0;
      rsp_beat_q <= '0;
      rsp_row_q <= '0;
      out_q <= '0;
      wr_en_q <= 1'b0;
      wr_last_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (go) begin
        row_base_q <= base_addr;
        req_addr_q <= base_addr;
        stride_q <= stride;
        bpr_q <= {2'b0, w_ext[BADDR_BITS+1:3]};
        height_q <= height;
        req_beat_q <= '0;
        req_row_q <= '0;
        rsp_beat_q <= '0;
        rsp_row_q <= '0;
      end
      // row base accumulates stride so no multiplier is needed
      if (accept) begin
        req_beat_q <= req_beat_last ? '0 : req_beat_q + (BADDR_BITS+1)'(1);
        req_row_q <= req_row_q + (CADDR_BITS+1)'(req_beat_last);
        row_base_q <= req_beat_last ? row_base_q + stride_q : row_base_q;
        req_addr_q <= req_beat_last ? row_base_q + stride_q : req_addr_q + 32'd8;
      end
      out_q <= out_q + OW'(accept) - OW'(rsp_ok);
      wr_en_q <= rsp_ok;
      wr_last_q <= rsp_ok && rsp_last;
      if (rsp_ok) begin
        wr_addr_q <= {rsp_row_q[CADDR_BITS-1:0], rsp_beat_q[BADDR_BITS-1:0]};
        wr_data_q <= rsp_data;
        rsp_beat_q <= rsp_beat_last ? '0 : rsp_beat_q + (BADDR_BITS+1)'(1);
        rsp_row_q <= rsp_row_q + (CADDR_BITS+1)'(rsp_beat_last);
      end
    end
  end
`ifdef FPU_FILL_ERR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else err_q <= err_q | (rsp_valid && !rsp_ok);
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_fpu_read_fill_ctrl.sv
// tb_fpu_read_fill_ctrl: directed bench for fpu_read_fill_ctrl with an in-order DRAM responder.
module tb_fpu_read_fill_ctrl;
  localparam int BB = 9, CB = 4;
  logic clk = 0, rst = 1, start = 0, req_ready = 1, rsp_valid = 0;
  logic req_valid, buf_wr_en, busy, done, err;
  logic [31:0] base_addr = 0, stride = 0, req_addr;
  logic [BB:0] width = 0;
  logic [CB:0] height = 0;
  logic [63:0] rsp_data = 0, buf_wr_data;
  logic [BB+CB-1:0] buf_wr_addr;
  int checks = 0, passes = 0;
  logic [31:0] req_log[$], pend_a[$];
  int pend_t[$];
  logic [12:0] wr_a[$];
  logic [63:0] wr_d[$];
  int cyc = 0, done_cnt = 0, rv_cnt = 0, outst = 0, max_outst = 0, last_due = 0;
  bit ready_rand = 0, rand_lat = 0;
  bit exp_err;

  fpu_read_fill_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .width(width), .height(height), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Responder/monitor: everything driven here applies to the next rising edge.
  initial begin : responder
    int lat;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      cyc++;
      req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (req_valid && req_ready) begin
        lat = rand_lat ? int'($urandom_range(1, 10)) : 3;
        last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        req_log.push_back(req_addr);
        pend_a.push_back(req_addr);
        pend_t.push_back(last_due);
        outst++;
      end
      if (buf_wr_en) begin
        wr_a.push_back(buf_wr_addr);
        wr_d.push_back(buf_wr_data);
      end
      if (done) done_cnt++;
      if (req_valid) rv_cnt++;
      rsp_valid = 0;
      if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
        a = pend_a.pop_front();
        void'(pend_t.pop_front());
        rsp_valid = 1;
        rsp_data = {a, ~a};
        if (outst > 0) outst--;
      end
      if (outst > max_outst) max_outst = outst;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rq(input int k);
    return k < req_log.size() ? req_log[k] : 32'hx;
  endfunction

  function automatic logic [12:0] wa(input int k);
    return k < wr_a.size() ? wr_a[k] : 13'hx;
  endfunction

  task automatic pulse(input logic [31:0] b, input logic [31:0] s, input int w, input int h);
    req_log.delete();
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
    rv_cnt = 0;
    base_addr = b;
    stride = s;
    width = 10'(w);
    height = 5'(h);
    start = 1;
    tick;
    start = 0;
    base_addr = 32'hDEAD_BEE8;
    stride = 32'h0000_0F08;
    width = 10'd3;
    height = 5'd7;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      tick;
      n++;
    end
    check({tag, "_done_in_time"}, 64'(n < limit), 64'd1);
    repeat (3) tick;
  endtask

  task automatic verify(input string tag, input logic [31:0] b, input logic [31:0] s, input int w, input int h);
    int bpr = (w + 7) / 8;
    int n = bpr * h;
    int bad_a = 0, bad_w = 0;
    logic [31:0] e;
    for (int k = 0; k < n; k++) begin
      e = b + 32'(k / bpr) * s + 32'((k % bpr) * 8);
      if (k < req_log.size() && req_log[k] !== e) bad_a++;
      if (k < wr_a.size() && (wr_a[k] !== 13'(((k / bpr) << 9) | (k % bpr)) || wr_d[k] !== {e, ~e})) bad_w++;
    end
    check({tag, "_req_count"}, 64'(req_log.size()), 64'(n));
    check({tag, "_wr_count"}, 64'(wr_a.size()), 64'(n));
    check({tag, "_req_addr_bad"}, 64'(bad_a), 64'd0);
    check({tag, "_wr_bad"}, 64'(bad_w), 64'd0);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin : main
    int n;
`ifdef FPU_FILL_ERR_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    repeat (3) tick;
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_wr_en", 64'(buf_wr_en), 64'd0);
    check("rst_req_addr", 64'(req_addr), 64'd0);
    rst = 0;
    tick;

    pulse(32'h1000, 32'h200, 16, 2);
    wait_done("basic", 200);
    verify("basic", 32'h1000, 32'h200, 16, 2);
    check("basic_req1", 64'(rq(1)), 64'h1008);
    check("basic_req2", 64'(rq(2)), 64'h1200);
    check("basic_req3", 64'(rq(3)), 64'h1208);
    check("basic_wa1", 64'(wa(1)), 64'd1);
    check("basic_wa2", 64'(wa(2)), 64'd512);
    check("basic_wa3", 64'(wa(3)), 64'd513);

    pulse(32'h2000, 32'h100, 9, 1);
    wait_done("w9", 200);
    verify("w9", 32'h2000, 32'h100, 9, 1);

    pulse(32'h3000, 32'h0, 0, 3);
    check("w0_done", 64'(done), 64'd1);
    check("w0_busy", 64'(busy), 64'd1);
    check("w0_req_valid", 64'(req_valid), 64'd0);
    tick;
    check("w0_done_drop", 64'(done), 64'd0);
    check("w0_idle", 64'(busy), 64'd0);
    tick;
    check("w0_no_reqs", 64'(rv_cnt), 64'd0);
    check("w0_no_writes", 64'(wr_a.size()), 64'd0);
    check("w0_done_pulses", 64'(done_cnt), 64'd1);

    pulse(32'h3000, 32'h8, 8, 0);
    check("h0_done", 64'(done), 64'd1);
    repeat (3) tick;
    check("h0_no_reqs", 64'(rv_cnt), 64'd0);

    pulse(32'hFFFF_FFF8, 32'h0, 16, 1);
    wait_done("wrap", 200);
    verify("wrap", 32'hFFFF_FFF8, 32'h0, 16, 1);
    check("wrap_req1", 64'(rq(1)), 64'h0);

    pulse(32'h5000, 32'h0, 64, 1);
    n = 0;
    while (req_log.size() < 8 && n < 200) begin
      tick;
      n++;
    end
    check("drain_reached", 64'(n < 200), 64'd1);
    base_addr = 32'h9000;
    width = 10'd8;
    height = 5'd1;
    start = 1;
    tick;
    start = 0;
    wait_done("drain", 200);
    repeat (10) tick;
    verify("drain", 32'h5000, 32'h0, 64, 1);
    pulse(32'h9000, 32'h40, 8, 1);
    wait_done("after_drain", 200);
    verify("after_drain", 32'h9000, 32'h40, 8, 1);

    ready_rand = 1;
    rand_lat = 1;
    max_outst = 0;
    pulse(32'h0004_0000, 32'h1000, 512, 8);
    wait_done("big", 20000);
    ready_rand = 0;
    rand_lat = 0;
    verify("big", 32'h0004_0000, 32'h1000, 512, 8);
    check("big_max_outstanding_ok", 64'(max_outst <= 4), 64'd1);

    pulse(32'h7000, 32'h100, 64, 2);
    n = 0;
    while (req_log.size() < 3 && n < 100) begin
      tick;
      n++;
    end
    check("rst_mid_reached", 64'(req_log.size()), 64'd3);
    rst = 1;
    #1;
    check("rst_mid_req_valid", 64'(req_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_req_addr", 64'(req_addr), 64'd0);
    check("rst_mid_wr_en", 64'(buf_wr_en), 64'd0);
    check("rst_mid_wr_addr", 64'(buf_wr_addr), 64'd0);
    check("rst_mid_wr_data", buf_wr_data, 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_err", 64'(err), 64'd0);
    wr_a.delete();
    wr_d.delete();
    tick;
    rst = 0;
    repeat (12) tick;
    check("late_beats_no_write", 64'(wr_a.size()), 64'd0);
    check("late_beats_err", 64'(err), 64'(exp_err));
    check("late_beats_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
